// File: rtl/image_morph_filter.sv
// image_morph_filter: KxK binary dilate/erode with internal line buffers and a 3-cycle sync-aligned pipeline
module image_morph_filter #(
  parameter int IMG_W  = 640,
  parameter int K      = 3,
  parameter int FG_BIT = 0
) (
  input  logic       clk_i,
  input  logic       a_rst_i,
  input  logic       i_hsyn,
  input  logic       i_vsyn,
  input  logic       i_en,
  input  logic [7:0] i_binary,
  input  logic       i_mode,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_en,
  output logic [7:0] o_binary,
  output logic       o_err
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(K);
  localparam logic [CW-1:0] C_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_MAX = RW'(K - 1);

  logic                  r_en_prev, r_vs_prev, r_full, r_mode, r_err;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [2:0]            r_hs_sr, r_vs_sr, r_en_sr;
  logic                  r_p1, r_first1, r_mode1, r_mode2;
  logic [RW-1:0]         r_row1;
  logic [K-2:0]          r_tap1;
  logic [K-1:0][K-1:0]   r_win;
  logic [7:0]            r_bin;
  logic                  r_lb [K-1][IMG_W];
  logic                  w_p, w_vs_rise, w_en_fall, w_mode, w_unused;
  logic [RW-1:0]         w_row;
  logic [K-1:0]          w_col;

  assign w_p       = i_binary[FG_BIT];
  assign w_unused  = &{1'b0, i_binary};
  assign w_vs_rise = i_vsyn & ~r_vs_prev;
  assign w_en_fall = r_en_prev & ~i_en;
  assign w_row     = w_vs_rise ? '0 : r_row;
  assign w_mode    = w_vs_rise ? i_mode : r_mode;
  assign o_hs      = r_hs_sr[2];
  assign o_vs      = r_vs_sr[2];
  assign o_en      = r_en_sr[2];
  assign o_binary  = r_bin;
  assign o_err     = r_err;

  // new window column: current pixel plus line-buffer taps, rows above the frame replaced by neutral
  always_comb begin
    w_col[0] = r_p1;
    for (int n = 0; n < K - 1; n++) w_col[n+1] = (r_row1 > RW'(n)) ? r_tap1[n] : r_mode1;
  end

  // line/frame counters, per-frame mode, overlength flag and sync delay lines
  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      r_en_prev <= 1'b0;
      r_vs_prev <= 1'b0;
      r_col     <= '0;
      r_full    <= 1'b0;
      r_row     <= '0;
      r_mode    <= 1'b0;
      r_err     <= 1'b0;
      r_hs_sr   <= '0;
      r_vs_sr   <= '0;
      r_en_sr   <= '0;
    end else begin
      r_en_prev <= i_en;
      r_vs_prev <= i_vsyn;
      r_col     <= w_en_fall ? '0 : (i_en && r_col != C_MAX) ? r_col + CW'(1) : r_col;
      r_full    <= w_en_fall ? 1'b0 : (i_en && r_col == C_MAX) ? 1'b1 : r_full;
      r_row     <= w_vs_rise ? '0 : (w_en_fall && r_row != R_MAX) ? r_row + RW'(1) : r_row;
      r_mode    <= w_mode;
      r_err     <= w_vs_rise ? 1'b0 : (i_en && r_full) ? 1'b1 : r_err;
      r_hs_sr   <= {r_hs_sr[1:0], i_hsyn};
      r_vs_sr   <= {r_vs_sr[1:0], i_vsyn};
      r_en_sr   <= {r_en_sr[1:0], i_en};
    end
  end

  // stage 1: register the pixel and its row/column/mode context alongside the RAM read
  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      r_p1     <= 1'b0;
      r_first1 <= 1'b0;
      r_mode1  <= 1'b0;
      r_row1   <= '0;
    end else begin
      r_p1     <= w_p;
      r_first1 <= (r_col == '0);
      r_mode1  <= w_mode;
      r_row1   <= w_row;
    end
  end

  // cascaded line buffers: read all taps, then push the pixel down one line per beat
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < K - 1; n++) r_tap1[n] <= r_lb[n][r_col];
    if (i_en) begin
      r_lb[0][r_col] <= w_p;
      for (int n = 1; n < K - 1; n++) r_lb[n][r_col] <= r_lb[n-1][r_col];
    end
  end

  // stage 2: shift the window on each beat; the first beat of a line flushes older columns to neutral
  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) begin
      r_win   <= '0;
      r_mode2 <= 1'b0;
    end else if (r_en_sr[0]) begin
      r_mode2 <= r_mode1;
      r_win   <= r_first1 ? {{(K-1)*K{r_mode1}}, w_col} : {r_win[K-2:0], w_col};
    end
  end

  // stage 3: OR/AND reduction, zero whenever the output strobe is low
  always_ff @(posedge clk_i or negedge a_rst_i) begin
    if (!a_rst_i) r_bin <= 8'd0;
    else          r_bin <= r_en_sr[1] ? {8{r_mode2 ? &r_win : |r_win}} : 8'd0;
  end
endmodule

// File: doc/image_morph_filter.md
# image_morph_filter

Parametrised binary morphology filter for the eye-tracking pixel pipeline. It applies a KxK square structuring element in dilate (OR) or erode (AND) mode, with the mode selected per frame. It replaces the fixed 3x3 dilate stage and sits after binarisation, before blob/pupil extraction. Line buffers are internal, border taps are masked to the neutral value, and sync signals are delayed to match the pixel latency.

## Interface
- IMG_W, 640, maximum active pixels per line; line-buffer depth.
- K, 3, kernel size; odd, legal values 3, 5, 7.
- FG_BIT, 0, bit of i_binary that marks foreground (1 = foreground).

- clk_i  in  1  pixel clock.
- a_rst_i  in  1  reset, asynchronous, active-low; clock clk_i.
- i_hsyn  in  1  horizontal sync.
- i_vsyn  in  1  vertical sync; rising edge = frame start.
- i_en  in  1  active-pixel strobe; one pixel per high cycle.
- i_binary  in  8  binarised pixel (0/255).
- i_mode  in  1  0 = dilate, 1 = erode; sampled at frame start.
- o_hs  out  1  i_hsyn delayed by LAT.
- o_vs  out  1  i_vsyn delayed by LAT.
- o_en  out  1  i_en delayed by LAT.
- o_binary  out  8  255 if result foreground, else 0. Forced 0 when o_en is low.
- o_err  out  1  sticky flag: a line exceeded IMG_W pixels this frame.

## Operation
- Foreground bit p = i_binary[FG_BIT]. The line buffers store only this 1 bit per pixel.
- **Column counter**
  - Increments on each i_en beat.
  - Cleared on the i_en falling edge (end of line).
  - Saturates at IMG_W-1.
- **Row counter**
  - Increments on each i_en falling edge.
  - Cleared on the i_vsyn rising edge.
  - Saturates at K-1; only the comparison "row >= k" is needed.
- **Line buffers**
  - K-1 single-port-per-cycle RAMs of IMG_W x 1 bit, cascaded.
  - On each beat at column c: read all taps at address c, then write p into buffer 0 and buffer n's old value into buffer n+1.
- **Window**
  - A KxK register array shifts one column per beat.
  - The new column is {line-buffer taps, current p}.
  - The current input pixel is the window's bottom-right element.
- **Border masking**
  - Neutral value N = 0 in dilate mode, 1 in erode mode.
  - A tap whose source row is before row 0 of the frame is replaced by N.
  - A tap whose source column is before column 0 of the line is replaced by N.
  - Line-buffer contents are never reset; masking makes stale data irrelevant.
- **Reduction**
  - Dilate: result = OR of the K*K masked taps.
  - Erode: result = AND of the K*K masked taps.
- **Spatial alignment**
  - Output pixel (r,c) is the result for the window whose bottom-right is input (r,c), i.e. centred on (r-R, c-R) with R=(K-1)/2.
  - Output pixel count per line and lines per frame equal the input counts.
- **Mode register**
  - Loaded from i_mode on the i_vsyn rising edge; reset value 0 (dilate).
  - Changes to i_mode mid-frame have no effect until the next frame.
- **Overlength lines**
  - A beat arriving while the column counter is already at IMG_W-1 sets o_err.
  - That beat is written to address IMG_W-1 (last location overwritten).
  - o_err clears on the i_vsyn rising edge.
- **Reset**
  - Reset values: o_hs, o_vs, o_en, o_binary, o_err = 0; counters 0; window cleared; sync delay lines 0.
  - Reset mid-frame: output resumes immediately with row 0 masking semantics. Results are correct from the next frame start.

## Timing
- LAT = 3 cycles, fixed for all K.
  - Edge 1: RAM read issued, p registered.
  - Edge 2: window shift with mask applied.
  - Edge 3: reduction registered into o_binary.
- o_hs, o_vs and o_en pass through a 3-stage shift register. They are cycle-aligned with o_binary.
- Back-to-back beats are supported (no stall, no backpressure). Gaps in i_en within a line are allowed: the window shifts only on beats.
- Frame start and the first beat may fall in the same cycle. The mode register and row clear take effect for that beat.
- The i_en falling edge and a row increment in the same cycle as i_vsyn rising: the clear takes priority.

## Test plan
- **Single-pixel dilate**: K=3, dilate, 16x8 frame, one foreground pixel at (2,3) -> o_binary=255 exactly at output rows 2..4, cols 3..5 (9 pixels), 0 elsewhere; o_en pulse count 128.
- **Full-white erode**: K=3, erode, all pixels 255 -> every output pixel 255, including row 0/col 0 (neutral masking).
- **Block erode**: K=5, erode, 5x5 white block at rows 1..5, cols 2..6 -> single 255 at output (5,6), all others 0.
- **Mid-frame mode change**: i_mode toggles 0->1 mid-frame -> that frame stays dilate; the next frame is eroded.
- **Overlength line**: IMG_W=16, one 18-pixel line -> o_err=1 from the 17th beat; cleared at the next i_vsyn rise. Syncs stay aligned at LAT=3.
- **Reset mid-frame**: assert a_rst_i mid-line -> all outputs 0 immediately. The following full frame matches the golden model bit-exactly.
